// File: rtl/path_streamer_if.sv
// path_streamer_if: valid/ready word stream from path_streamer toward the HPS bridge FIFO.
//   m_valid  word valid (driven by master)
//   m_ready  downstream accept (driven by slave)
//   m_data   32-bit word (header or {x[15:0], y[15:0]} coordinate)
//   m_last   final word of a transfer
interface path_streamer_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/path_streamer.sv
// path_streamer: reads the Dijkstra engine's result path once a search succeeds and streams
// it as one header word {HDR_TAG, zeros, len} followed by the coordinates in start-to-goal
// order (path[len-1] down to path[0]).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   path_valid     engine success level; a rising edge triggers a transfer
//   search_start   engine start pulse; aborts any transfer in progress
//   path_len       engine coordinate count, signed, clamped to [0, MAX_LEN]
//   path           engine path array, goal-first, held stable by the engine
//   m_if           output word stream (master side)
//   busy           high while a transfer is in progress
//   overrun        sticky: a trigger arrived while a transfer was in progress
//   clear_overrun  synchronous clear for overrun
module path_streamer #(
    parameter int unsigned MAX_LEN = 100,
    parameter logic [15:0] HDR_TAG = 16'hA5A5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     path_valid,
    input  logic                     search_start,
    input  logic [31:0]              path_len,
    input  logic [MAX_LEN-1:0][31:0] path,
    path_streamer_if.master          m_if,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StData
    } state_e;

    state_e             r_state;
    logic               r_pv_q;
    logic               r_trig;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [31:0]        r_pre;
    logic               r_m_valid;
    logic [31:0]        r_m_data;
    logic               r_m_last;
    logic               r_overrun;

    logic               w_trig;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_rd_idx;
    logic [31:0]        w_rd_data;

    assign w_trig   = path_valid & ~r_pv_q;
    assign w_accept = r_m_valid & m_if.m_ready;

    // Clamp the engine's signed count into [0, MAX_LEN].
    always_comb begin
        w_len = '0;
        if (path_len[31]) begin
            w_len = '0;
        end else if (path_len > 32'(MAX_LEN)) begin
            w_len = LEN_W'(MAX_LEN);
        end else begin
            w_len = path_len[LEN_W-1:0];
        end
    end

    // Index of the word that follows the one about to be loaded into m_data. It is read into
    // r_pre one beat ahead so m_data is always loaded from a register, never from path directly.
    always_comb begin
        w_rd_idx = '0;
        unique case (r_state)
            StIdle:   w_rd_idx = w_len - LEN_W'(1);
            StHeader: w_rd_idx = r_idx - LEN_W'(1);
            StData:   w_rd_idx = r_idx - LEN_W'(2);
            default:  w_rd_idx = '0;
        endcase
    end

    // Wrapped indices (e.g. len == 0) read as zero; their data is never emitted.
    assign w_rd_data = (32'(w_rd_idx) < MAX_LEN) ? path[w_rd_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_pv_q    <= 1'b0;
            r_trig    <= 1'b0;
            r_len     <= '0;
            r_idx     <= '0;
            r_pre     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pv_q <= path_valid;
            // A trigger coinciding with search_start is dropped outright.
            r_trig <= w_trig & ~search_start;

            // Set beats clear when both happen in the same cycle.
            if (r_trig && !search_start && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end

            if (search_start) begin
                // Abort: the partial packet is cut without m_last.
                r_state   <= StIdle;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (r_trig) begin
                            r_len     <= w_len;
                            r_idx     <= w_len - LEN_W'(1);
                            r_pre     <= w_rd_data;
                            r_m_valid <= 1'b1;
                            r_m_data  <= {HDR_TAG, {(16 - LEN_W){1'b0}}, w_len};
                            r_m_last  <= (w_len == '0);
                            r_state   <= StHeader;
                        end
                    end
                    StHeader: begin
                        if (w_accept) begin
                            if (r_len == '0) begin
                                r_m_valid <= 1'b0;
                                r_m_last  <= 1'b0;
                                r_state   <= StIdle;
                            end else begin
                                r_m_data <= r_pre;
                                r_m_last <= (r_idx == '0);
                                r_pre    <= w_rd_data;
                                r_state  <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (w_accept) begin
                            if (r_idx == '0) begin
                                r_m_valid <= 1'b0;
                                r_m_last  <= 1'b0;
                                r_state   <= StIdle;
                            end else begin
                                r_idx    <= r_idx - LEN_W'(1);
                                r_m_data <= r_pre;
                                r_m_last <= (r_idx == LEN_W'(1));
                                r_pre    <= w_rd_data;
                            end
                        end
                    end
                    default: begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= StIdle;
                    end
                endcase
            end
        end
    end

    assign m_if.m_valid = r_m_valid;
    assign m_if.m_data  = r_m_data;
    assign m_if.m_last  = r_m_last;
    assign busy         = (r_state != StIdle);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_path_streamer.sv
// tb_path_streamer: directed self-checking bench for path_streamer.
module tb_path_streamer;

    localparam int unsigned MAX_LEN = 100;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     path_valid;
    logic                     search_start;
    logic [31:0]              path_len;
    logic [MAX_LEN-1:0][31:0] path;
    logic                     busy;
    logic                     overrun;
    logic                     clear_overrun;

    path_streamer_if m_if ();

    path_streamer #(
        .MAX_LEN(MAX_LEN),
        .HDR_TAG(16'hA5A5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .path_valid   (path_valid),
        .search_start (search_start),
        .path_len     (path_len),
        .path         (path),
        .m_if         (m_if),
        .busy         (busy),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc;
    int          q_unstable;
    logic        q_first_busy;

    // Receiver: drives m_ready per mode (0: always 1, 1: pattern 1,0,0,...) and records every
    // accepted word until one with m_last or until the cycle budget runs out.
    task automatic collect(input int mode, input int budget);
        logic [31:0] held;
        logic        held_last;
        logic        stalled;
        stalled   = 1'b0;
        held      = '0;
        held_last = 1'b0;
        q_data.delete();
        q_last.delete();
        q_cyc        = 0;
        q_unstable   = 0;
        q_first_busy = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            q_cyc++;
            if (k == 0) q_first_busy = busy;
            if (stalled && (m_if.m_valid !== 1'b1 || m_if.m_data !== held ||
                            m_if.m_last !== held_last)) begin
                q_unstable++;
            end
            m_if.m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
                q_data.push_back(m_if.m_data);
                q_last.push_back(m_if.m_last);
                stalled = 1'b0;
                if (m_if.m_last === 1'b1) break;
            end else begin
                stalled   = (m_if.m_valid === 1'b1);
                held      = m_if.m_data;
                held_last = m_if.m_last;
            end
        end
    endtask

    task automatic pulse_pv();
        @(negedge clk);
        path_valid = 1'b1;
        @(negedge clk);
        path_valid = 1'b0;
    endtask

    task automatic load_path3();
        path     = '0;
        path[0]  = 32'h0082_0043;
        path[1]  = 32'h0050_0030;
        path[2]  = 32'h0010_0010;
        path_len = 32'd3;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        path_valid    = 1'b0;
        search_start  = 1'b0;
        path_len      = '0;
        path          = '0;
        clear_overrun = 1'b0;
        m_if.m_ready  = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({m_if.m_valid, m_if.m_last, busy, overrun, m_if.m_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b l=%b b=%b o=%b d=%h required all zero",
                     m_if.m_valid, m_if.m_last, busy, overrun, m_if.m_data);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b b=%b required 0 0", m_if.m_valid, busy);
        end
    endtask

    task automatic test_normal();
        logic [31:0] exp[4];
        logic [3:0]  lastv;
        exp[0] = 32'hA5A5_0003;
        exp[1] = 32'h0010_0010;
        exp[2] = 32'h0050_0030;
        exp[3] = 32'h0082_0043;
        load_path3();
        m_if.m_ready = 1'b1;
        pulse_pv();
        n_assert++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_latency_early: got v=%b b=%b required 0 0", m_if.m_valid, busy);
        end
        collect(0, 20);
        n_assert++;
        if (q_first_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_busy_at_header: got %b required 1", q_first_busy);
        end
        n_assert++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL normal_count: got %0d required 4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_assert++;
            if (q_data[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL normal_word%0d: got %h required %h", i, q_data[i], exp[i]);
            end
        end
        lastv = '0;
        for (int i = 0; i < 4 && i < q_last.size(); i++) lastv[i] = q_last[i];
        n_assert++;
        if (lastv !== 4'b1000) begin
            n_fail++;
            $display("FAIL normal_last: got %b required 1000", lastv);
        end
        n_assert++;
        if (q_cyc != 4) begin
            n_fail++;
            $display("FAIL normal_cycles: got %0d required 4", q_cyc);
        end
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_end: got b=%b v=%b required 0 0", busy, m_if.m_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp[4];
        exp[0] = 32'hA5A5_0003;
        exp[1] = 32'h0010_0010;
        exp[2] = 32'h0050_0030;
        exp[3] = 32'h0082_0043;
        load_path3();
        m_if.m_ready = 1'b0;
        pulse_pv();
        collect(1, 40);
        n_assert++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d required 4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_assert++;
            if (q_data[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h required %h", i, q_data[i], exp[i]);
            end
        end
        n_assert++;
        if (q_unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes while stalled required 0", q_unstable);
        end
        n_assert++;
        if (q_cyc != 10) begin
            n_fail++;
            $display("FAIL bp_cycles: got %0d required 10", q_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_clamp();
        int          bad;
        int          p;
        logic [31:0] e;
        // Zero length: header only, with m_last.
        path     = '0;
        path_len = 32'd0;
        m_if.m_ready = 1'b1;
        pulse_pv();
        collect(0, 10);
        n_assert++;
        if (q_data.size() != 1 || q_data[0] !== 32'hA5A5_0000 || q_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_zero: got n=%0d d=%h l=%b required 1 a5a50000 1",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx,
                     (q_last.size() > 0) ? q_last[0] : 1'bx);
        end
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_busy: got %b required 0", busy);
        end
        // Over-long count clamps to MAX_LEN.
        for (int k = 0; k < int'(MAX_LEN); k++) begin
            path[k] = {16'h1000 + 16'(k), 16'h2000 - 16'(k)};
        end
        path_len = 32'd150;
        pulse_pv();
        collect(0, 200);
        n_assert++;
        if (q_data.size() != 101) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d required 101", q_data.size());
        end
        n_assert++;
        if (q_data.size() < 1 || q_data[0] !== 32'hA5A5_0064) begin
            n_fail++;
            $display("FAIL clamp_header: got %h required a5a50064",
                     (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        bad = 0;
        for (int j = 1; j < q_data.size() && j <= 100; j++) begin
            p = 100 - j;
            e = {16'h1000 + 16'(p), 16'h2000 - 16'(p)};
            if (q_data[j] !== e || q_last[j] !== (j == 100)) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clamp_coords: got %0d bad coords required 0", bad);
        end
        @(negedge clk);
        // Negative count clamps to zero.
        path_len = 32'hFFFF_FFFF;
        pulse_pv();
        collect(0, 10);
        n_assert++;
        if (q_data.size() != 1 || q_data[0] !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL clamp_negative: got n=%0d d=%h required 1 a5a50000",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        load_path3();
        m_if.m_ready = 1'b0;
        pulse_pv();
        @(negedge clk);
        m_if.m_ready = 1'b1;        // accept the header
        @(negedge clk);
        m_if.m_ready = 1'b0;        // stall on the first coordinate
        path_valid   = 1'b1;        // second rising edge while busy
        repeat (2) @(negedge clk);
        n_assert++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        n_assert++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 32'h0010_0010) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%b d=%h required 1 00100010",
                     m_if.m_valid, m_if.m_data);
        end
        collect(0, 10);
        n_assert++;
        if (q_data.size() != 3 || q_data[0] !== 32'h0010_0010 || q_data[2] !== 32'h0082_0043) begin
            n_fail++;
            $display("FAIL overrun_rest: got n=%0d required 3 words ending 00820043",
                     q_data.size());
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_no_second: got v=%b b=%b required 0 0", m_if.m_valid, busy);
        end
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        n_assert++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        path_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic seen_last;
        int   acc;
        load_path3();
        m_if.m_ready = 1'b1;
        pulse_pv();
        seen_last = 1'b0;
        acc       = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (m_if.m_valid === 1'b1) acc++;
            if (m_if.m_last === 1'b1) seen_last = 1'b1;
        end
        @(negedge clk);
        if (m_if.m_last === 1'b1) seen_last = 1'b1;
        m_if.m_ready = 1'b0;
        search_start = 1'b1;
        @(negedge clk);
        search_start = 1'b0;
        n_assert++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: got v=%b b=%b required 0 0", m_if.m_valid, busy);
        end
        n_assert++;
        if (seen_last !== 1'b0 || acc != 2) begin
            n_fail++;
            $display("FAIL abort_truncate: got last=%b accepted=%0d required 0 2", seen_last, acc);
        end
        m_if.m_ready = 1'b1;
        pulse_pv();
        collect(0, 10);
        n_assert++;
        if (q_data.size() != 4 || q_data[0] !== 32'hA5A5_0003) begin
            n_fail++;
            $display("FAIL abort_restart: got n=%0d required 4 words from a5a50003",
                     q_data.size());
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        load_path3();
        m_if.m_ready = 1'b1;
        pulse_pv();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_assert++;
        if ({m_if.m_valid, m_if.m_last, busy, overrun, m_if.m_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b l=%b b=%b o=%b d=%h required all zero",
                     m_if.m_valid, m_if.m_last, busy, overrun, m_if.m_data);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_idle: got v=%b b=%b required 0 0", m_if.m_valid, busy);
        end
        pulse_pv();
        collect(0, 10);
        n_assert++;
        if (q_data.size() != 4 || q_data[0] !== 32'hA5A5_0003 || q_data[3] !== 32'h0082_0043) begin
            n_fail++;
            $display("FAIL async_restart: got n=%0d required 4 words a5a50003..00820043",
                     q_data.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_pressure();
        test_empty_clamp();
        test_overrun();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/path_streamer.md
# path_streamer

Reads the result path out of the Dijkstra pathfinding engine once a search succeeds, and streams it as 32-bit words over a valid/ready interface toward the HPS bridge FIFO. The engine writes coordinates goal-first into its `path` array and reports the count on `i`. This block snapshots that count, emits one header word, then emits the coordinates in start-to-goal order. It sits between the Dijkstra engine and the Avalon/HPS-side FIFO writer.

## Interface
- `MAX_LEN`, 100: depth of the engine's `path` array; the maximum number of coordinates streamed.
- `HDR_TAG`, 16'hA5A5: upper half of the header word.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `path_valid`  in  1  engine `success` level; a 0->1 transition triggers a transfer.
- `search_start`  in  1  engine `start` pulse; aborts any transfer in progress.
- `path_len`  in  32  engine `i`, interpreted as a signed integer.
- `path`  in  MAX_LEN x 32  engine path array; each element is a coord `{x[15:0], y[15:0]}`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  32  output word.
- `m_last`  out  1  marks the final word of the transfer.
- `busy`  out  1  high from trigger until the last word is accepted or the transfer is aborted.
- `overrun`  out  1  sticky error flag.
- `clear_overrun`  in  1  synchronous clear for `overrun`.

## Operation
- A 1-cycle-delayed copy of `path_valid` is registered for edge detection. `trig = path_valid & ~path_valid_q`.
- States: IDLE, HEADER, DATA.
- **IDLE**
  - On `trig`: latch `len`, preset `idx = len-1`, go to HEADER.
  - `len` is clamped: `path_len < 0` gives 0; `path_len > MAX_LEN` gives MAX_LEN; otherwise `len = path_len`.
  - `len` and `idx` are 7-bit unsigned (enough for MAX_LEN=100).
- **HEADER**
  - `m_valid=1`, `m_data = {HDR_TAG, 9'b0, len}`, `m_last = (len==0)`.
  - On `m_valid & m_ready`: go to IDLE if `len==0`, otherwise go to DATA.
- **DATA**
  - `m_valid=1`, `m_data = path[idx]`, `m_last = (idx==0)`.
  - On accept: if `idx==0` go to IDLE, otherwise `idx = idx-1`.
  - Coordinates are therefore emitted in reverse index order, `path[len-1]` down to `path[0]`, which is start-to-goal.
- Stream rules:
  - Once `m_valid` is asserted, `m_valid`, `m_data` and `m_last` stay stable until accepted.
  - `m_valid` never depends combinationally on `m_ready`.
- `m_data` is driven from registers. The indexed `path` read is registered one beat ahead, so there is no combinational path from `path` to `m_data`.
- The engine holds `path` stable until the next `search_start`. The block does not copy the array.
- `search_start` in any state:
  - Next state is IDLE; `m_valid` and `busy` go low the following cycle.
  - A partially sent packet is truncated without `m_last`.
  - Downstream detects the truncation by the next header tag.
- If `trig` occurs while not in IDLE, it is ignored and sets `overrun`. If `trig` and `search_start` coincide, `search_start` wins and no transfer starts.
- `overrun` is cleared only by `clear_overrun` or reset. A set in the same cycle as `clear_overrun` takes priority over the clear.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE; `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `overrun`=0, `path_valid_q`=0, `len`=0, `idx`=0.
- Trigger latency:
  - `path_valid` sampled high at edge N (and low at N-1) means HEADER is presented with `m_valid=1` after edge N+1.
  - `busy` is high from the same point.
- Throughput with `m_ready` held high: one word per cycle; a total of `len+1` cycles from the header to the last accept.
- Back-pressure: `m_ready=0` stalls indefinitely with outputs held.
- End of transfer:
  - Last accept at edge M means `m_valid`=0 and `busy`=0 after edge M.
  - A new `trig` is accepted from edge M+1 onward.
- `path_valid` held high across transfers does not retrigger; it must fall and rise again.

## Test plan
- **Normal 3-point path.** `path_len=3`; `path[0]=0082_0043`, `path[1]=0050_0030`, `path[2]=0010_0010`; `m_ready=1`; pulse `path_valid`.
  - Required: words `A5A5_0003`, `0010_0010`, `0050_0030`, `0082_0043` on consecutive cycles.
  - `m_last` high only on the 4th word; `busy` low the cycle after.
- **Back-pressure.** Same stimulus, with `m_ready` toggling 1,0,0,1,...
  - Required: the same 4 words in the same order, no duplicates or drops, and data stable while stalled.
- **Empty and clamp.**
  - `path_len=0` gives the single word `A5A5_0000` with `m_last=1`.
  - `path_len=150` gives header `A5A5_0064` followed by 100 coords.
  - `path_len=-1` gives `A5A5_0000`.
- **Overrun.** During DATA with `m_ready=0`, drop and re-raise `path_valid`.
  - Required: `overrun=1`, the current transfer completes unchanged, and no second header.
  - `clear_overrun` pulse gives `overrun=0` next cycle.
- **Abort.** Pulse `search_start` after 2 of 4 words are accepted.
  - Required: `m_valid=0`, `busy=0` next cycle, and no `m_last` seen.
  - A subsequent `path_valid` edge starts a fresh header.
- **Async reset.** Assert `reset=0` mid-DATA, between clock edges.
  - Required: all outputs go to their reset values immediately.
  - After `reset=1`, the block waits in IDLE for a new `path_valid` edge.
